// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage for the mini-CPU. It owns the program counter and drives the
// address of a combinational instruction ROM. Fetched words go into a 2-entry
// queue that is handed to decode. Unconditional JMPs are folded here and never
// reach decode. Execute can override the PC with a redirect, which also
// flushes the queue.
//
// Ports:
//   clk, rst_n      - clock; synchronous active-low reset
//   rom_addr        - ROM address, always equal to the PC register
//   rom_instr       - ROM data for rom_addr, valid in the same cycle
//   fetch_en        - when low, nothing is fetched and the PC holds
//   out_valid       - queue head holds an instruction
//   out_ready       - decode accepts the head this cycle
//   out_instr       - head instruction
//   out_pc          - address the head instruction was fetched from
//   redirect_valid  - execute-stage PC override (flushes the queue)
//   redirect_pc     - new PC for a redirect
//   jmp_count       - number of JMPs folded since reset, wraps 255 -> 0
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. out_valid does not depend on out_ready, and out_instr/out_pc
// hold steady while out_valid is high and out_ready is low. A redirect in the
// same cycle discards the beat even if both are high.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned           ADDR_W   = 8,
    parameter int unsigned           INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               fetch_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [7:0]         jmp_count
);

    localparam logic [4:0] OP_JMP = 5'b11110;

    // Registered state
    logic [ADDR_W-1:0]  pc_q,         pc_d;
    logic [ADDR_W-1:0]  fifo_pc_q    [2];
    logic [ADDR_W-1:0]  fifo_pc_d    [2];
    logic [INSTR_W-1:0] fifo_instr_q [2];
    logic [INSTR_W-1:0] fifo_instr_d [2];
    logic [1:0]         count_q,      count_d;
    logic               rd_ptr_q,     rd_ptr_d;
    logic               wr_ptr_q,     wr_ptr_d;
    logic [7:0]         jmp_count_q,  jmp_count_d;

    // Decode of the word currently on the ROM bus
    logic               is_jmp;
    logic [ADDR_W-1:0]  jmp_target;
    logic               pop;
    logic               can_fetch;
    logic               push;

    assign is_jmp     = (rom_instr[INSTR_W-1 -: 5] == OP_JMP);
    assign jmp_target = rom_instr[INSTR_W-6 -: ADDR_W];

    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue still fetches
    // when decode is taking the head.
    assign can_fetch  = fetch_en & ((count_q < 2'd2) | pop);

    always_comb begin
        pc_d         = pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        jmp_count_d  = jmp_count_q;
        push         = 1'b0;

        if (redirect_valid) begin
            // Flush wins over any pop or fetch in the same cycle.
            pc_d     = redirect_pc;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (can_fetch) begin
                if (is_jmp) begin
                    // Folded JMP: retarget the PC, nothing enters the queue.
                    pc_d        = jmp_target;
                    jmp_count_d = jmp_count_q + 8'd1;
                end else begin
                    push = 1'b1;
                    pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end

            if (push) begin
                fifo_pc_d[wr_ptr_q]    = pc_q;
                fifo_instr_d[wr_ptr_q] = rom_instr;
                wr_ptr_d               = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fifo_pc_q    <= '{default: '0};
            fifo_instr_q <= '{default: '0};
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            jmp_count_q  <= 8'd0;
        end else begin
            pc_q         <= pc_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            jmp_count_q  <= jmp_count_d;
        end
    end

    assign rom_addr  = pc_q;
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign jmp_count = jmp_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A behavioural model (PC plus a queue of {pc, instr})
// shadows the DUT every cycle; directed scenarios and a stimulus table add
// hand-derived expectations for the interesting corners.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_instr;
  logic        fetch_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  jmp_count;

  logic [15:0] rom [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_instr = rom[rom_addr];

  instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .fetch_en       (fetch_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .jmp_count      (jmp_count)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ROM helpers ----------------
  function automatic logic [15:0] mk_jmp(input logic [7:0] tgt);
    return {5'b11110, tgt, 3'b000};
  endfunction

  // Opcode a%30 is never 30 (the JMP opcode).
  function automatic logic [15:0] mk_op(input int a);
    logic [4:0] opc;
    logic [7:0] lo;
    opc = 5'(a % 30);
    lo  = 8'(a);
    return {opc, 3'b101, lo};
  endfunction

  task automatic fill_rom();
    for (int a = 0; a < 256; a++) rom[a] = mk_op(a);
    rom[7] = mk_jmp(8'd1);
  endtask

  // ---------------- reference model ----------------
  logic [23:0] exp_q[$];   // {pc, instr} in delivery order
  logic [7:0]  m_pc;
  logic [7:0]  m_jmp;
  bit          m_fresh;    // nothing pushed since reset: head data reads zero
  bit          m_known = 1'b0;
  logic [7:0]  beats[$];   // out_pc of every accepted beat

  task automatic check_model();
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("jmp_count", 32'(jmp_count), 32'(m_jmp));
    if (exp_q.size() != 0) begin
      chk("out_pc", 32'(out_pc), 32'(exp_q[0][23:16]));
      chk("out_instr", 32'(out_instr), 32'(exp_q[0][15:0]));
    end else if (m_fresh) begin
      chk("reset_out_pc", 32'(out_pc), 32'd0);
      chk("reset_out_instr", 32'(out_instr), 32'd0);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic rd,
                            input logic rv, input logic [7:0] rp);
    int          n;
    bit          pop;
    logic [15:0] ins;
    if (!r) begin
      m_pc    = 8'd0;
      exp_q.delete();
      m_jmp   = 8'd0;
      m_fresh = 1'b1;
      m_known = 1'b1;
    end else if (m_known) begin
      n   = exp_q.size();
      pop = (n != 0) && rd;
      if (rv) begin
        exp_q.delete();
        m_pc = rp;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (f && (n < 2 || pop)) begin
          ins = rom[m_pc];
          if (ins[15:11] == 5'b11110) begin
            m_pc  = ins[10:3];
            m_jmp = m_jmp + 8'd1;
          end else begin
            exp_q.push_back({m_pc, ins});
            m_pc    = m_pc + 8'd1;
            m_fresh = 1'b0;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge, checks the registered
  // outputs against the model, then advances the model past the next edge.
  task automatic cycle(input logic r, input logic f, input logic rd,
                       input logic rv, input logic [7:0] rp);
    @(negedge clk);
    rst_n = r; fetch_en = f; out_ready = rd; redirect_valid = rv; redirect_pc = rp;
    if (m_known) check_model();
    if (r && !rv && out_valid && out_ready) beats.push_back(out_pc);
    model_step(r, f, rd, rv, rp);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic       rst_n;
    logic       fe;
    logic       rdy;
    logic       chk_en;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] exp_beat;
    logic [7:0] jmp_before;

    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'd0;
    fill_rom();

    // Backpressure after reset: ready low for six cycles, then high.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd2};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd2};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 8'd4};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd5};

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst_n, tbl[i].fe, tbl[i].rdy, 1'b0, 8'd0);
      if (tbl[i].chk_en) begin
        chk("bp_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
        chk("bp_rom_addr", 32'(rom_addr), 32'(tbl[i].exp_addr));
        if (tbl[i].exp_valid) begin
          chk("bp_out_pc", 32'(out_pc), 32'(tbl[i].exp_pc));
          chk("bp_out_instr", 32'(out_instr), 32'(rom[tbl[i].exp_pc]));
        end
      end
    end

    // Program loop: 0..6 then JMP 1 at address 7.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    beats.delete();
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      if (i == 9)  chk("prog_jmp_loop1", 32'(jmp_count), 32'd1);
      if (i == 16) chk("prog_jmp_loop2", 32'(jmp_count), 32'd2);
    end
    chk("prog_beat_count", 32'(beats.size() >= 20), 32'd1);
    for (int k = 0; k < 20 && k < beats.size(); k++) begin
      exp_beat = (k < 7) ? 8'(k) : 8'(1 + (k - 7) % 6);
      chk("prog_beat_pc", 32'(beats[k]), 32'(exp_beat));
    end

    // Self-loop at address 3, then fetch disabled.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rom[3] = mk_jmp(8'd3);
    beats.delete();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      if (i == 10) chk("loop_jmp_running", 32'(jmp_count), 32'd6);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("loop_jmp_frozen", 32'(jmp_count), 32'd7);
      chk("loop_drained", 32'(out_valid), 32'd0);
      chk("loop_rom_addr", 32'(rom_addr), 32'd3);
    end
    chk("loop_beats", 32'(beats.size()), 32'd3);
    foreach (beats[k]) chk("loop_beat_pc", 32'(beats[k]), 32'(k));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rom[3] = mk_op(3);

    // Redirect while the queue holds pc 2,3.
    beats.delete();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
    chk("redir_head_before", 32'(out_pc), 32'd2);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("redir_valid_low", 32'(out_valid), 32'd0);
    chk("redir_rom_addr", 32'(rom_addr), 32'd5);
    chk("redir_no_stale_beat", 32'(beats.size()), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("redir_new_valid", 32'(out_valid), 32'd1);
    chk("redir_new_pc", 32'(out_pc), 32'd5);

    // PC wrap-around 254 -> 255 -> 0.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    beats.delete();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd254);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("wrap_beat_count", 32'(beats.size() >= 3), 32'd1);
    if (beats.size() >= 3) begin
      chk("wrap_beat0", 32'(beats[0]), 32'd254);
      chk("wrap_beat1", 32'(beats[1]), 32'd255);
      chk("wrap_beat2", 32'(beats[2]), 32'd0);
    end

    // Reset mid-operation with a full queue and pc 40.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rom[36] = mk_jmp(8'd38);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd36);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_addr", 32'(rom_addr), 32'd40);
    chk("mid_pre_jmp", 32'(jmp_count), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_jmp", 32'(jmp_count), 32'd0);
    chk("mid_rst_instr", 32'(out_instr), 32'd0);

    // Random traffic against the model, ROM sprinkled with JMPs.
    for (int a = 0; a < 256; a++)
      rom[a] = ($urandom_range(0, 7) == 0) ? mk_jmp(8'($urandom_range(0, 255))) : mk_op(a);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    jmp_before = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) != 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0),
            8'($urandom_range(0, 255)));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
